// File: rtl/booth_pkg.sv
// Shared types and helpers for the booth multiplier / divider pair.
// Holds the divider state encoding, the default operand width and a magnitude helper.
package booth_pkg;

    localparam int WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Callers sign-extend into 64 bits, so the most negative operand of any
    // width up to 32 bits still yields its exact positive magnitude.
    function automatic logic [63:0] mag(input logic [63:0] v);
        return v[63] ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/booth_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int width = 6
) (
    input  logic [width:0]   rem_in,
    input  logic             bit_in,
    input  logic [width-1:0] dvs,
    output logic [width:0]   rem_out,
    output logic             q_bit
);

    logic [width:0]   shifted_s;
    logic [width+1:0] diff_s;
    logic             unused_rem_s;

    // The incoming remainder is always below the divisor, so its top bit is never set.
    assign unused_rem_s = rem_in[width];

    // Trial subtraction; a borrow in the extra top bit means restore.
    always_comb begin
        shifted_s = {rem_in[width-1:0], bit_in};
        diff_s    = {1'b0, shifted_s} - {2'b00, dvs};
        if (diff_s[width+1] == 1'b0) begin
            rem_out = diff_s[width:0];
            q_bit   = 1'b1;
        end else begin
            rem_out = shifted_s;
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/booth_div.sv
// Sequential signed divider: 2*width-bit dividend by width-bit divisor, restoring on magnitudes.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
module booth_div
    import booth_pkg::*;
#(
    parameter int width = WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*width-1:0] dividend,
    input  logic [width-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [width-1:0]   quotient,
    output logic [width-1:0]   remainder,
    output logic               overflow,
    output logic               div_zero
);

    localparam int DW = 2 * width;
    localparam int QW = DW + 1;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    state_t           state_r;
    logic [DW-1:0]    dvd_r;
    logic [DW-1:0]    quo_r;
    logic [width-1:0] dvs_r;
    logic [width:0]   rem_r;
    logic [CW-1:0]    cnt_r;
    logic             sign_q_r;
    logic             sign_r_r;
    logic             divz_r;

    logic [63:0]      dvd_mag_s;
    logic [63:0]      dvs_mag_s;
    logic [width:0]   rem_nxt_s;
    logic             q_bit_s;
    logic [QW-1:0]    qs_s;
    logic [width-1:0] rs_s;
    logic             ovf_s;
    logic             unused_mag_s;

    assign dvd_mag_s = mag({{(64-DW){dividend[DW-1]}}, dividend});
    assign dvs_mag_s = mag({{(64-width){divisor[width-1]}}, divisor});
    assign unused_mag_s = ^{dvd_mag_s[63:DW], dvs_mag_s[63:width], rem_r[width]};

    div_step #(.width(width)) u_step (
        .rem_in  (rem_r),
        .bit_in  (dvd_r[DW-1]),
        .dvs     (dvs_r),
        .rem_out (rem_nxt_s),
        .q_bit   (q_bit_s)
    );

    // Sign restoration; the extra quotient bit keeps +2^(DW-1) representable for the range test.
    always_comb begin
        if (sign_q_r) begin
            qs_s = ~{1'b0, quo_r} + QW'(1);
        end else begin
            qs_s = {1'b0, quo_r};
        end
        if (sign_r_r) begin
            rs_s = ~rem_r[width-1:0] + width'(1);
        end else begin
            rs_s = rem_r[width-1:0];
        end
        ovf_s = ~((&qs_s[QW-1:width-1]) | ~(|qs_s[QW-1:width-1]));
    end

    // Control FSM with datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            dvd_r     <= {DW{1'b0}};
            quo_r     <= {DW{1'b0}};
            dvs_r     <= {width{1'b0}};
            rem_r     <= {(width+1){1'b0}};
            cnt_r     <= {CW{1'b0}};
            sign_q_r  <= 1'b0;
            sign_r_r  <= 1'b0;
            divz_r    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= {width{1'b0}};
            remainder <= {width{1'b0}};
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        dvd_r    <= dvd_mag_s[DW-1:0];
                        dvs_r    <= dvs_mag_s[width-1:0];
                        sign_q_r <= dividend[DW-1] ^ divisor[width-1];
                        sign_r_r <= dividend[DW-1];
                        rem_r    <= {(width+1){1'b0}};
                        quo_r    <= {DW{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        busy     <= 1'b1;
                        if (divisor == {width{1'b0}}) begin
                            divz_r  <= 1'b1;
                            state_r <= FIX;
                        end else begin
                            divz_r  <= 1'b0;
                            state_r <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    rem_r <= rem_nxt_s;
                    quo_r <= {quo_r[DW-2:0], q_bit_s};
                    dvd_r <= {dvd_r[DW-2:0], 1'b0};
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                    if (divz_r) begin
                        quotient  <= {width{1'b0}};
                        remainder <= {width{1'b0}};
                        overflow  <= 1'b0;
                        div_zero  <= 1'b1;
                    end else begin
                        quotient  <= qs_s[width-1:0];
                        remainder <= rs_s;
                        overflow  <= ovf_s;
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_div.sv
// Directed self-checking bench for booth_div (width=6): signs, overflow, divide by zero,
// handshake corners, mid-operation reset and the multiply/divide round trip.
module tb_booth_div;

    localparam int W = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           overflow;
    logic           div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_div #(.width(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    // Issue one operation and count clock edges after the accept edge until done is seen.
    task automatic run_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv, output int edges);
        @(negedge clk);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!done && edges < 40);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, overflow, div_zero, quotient, remainder} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {busy, done, overflow, div_zero, quotient, remainder});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int e;
        run_op(12'd35, 6'd6, e);
        n_checks++;
        if (e !== 13) begin n_fail++; $display("FAIL basic_latency: got %0d expected 13", e); end
        n_checks++;
        if (quotient !== 6'd5) begin n_fail++; $display("FAIL basic_q: got %b expected 000101", quotient); end
        n_checks++;
        if (remainder !== 6'd5) begin n_fail++; $display("FAIL basic_r: got %b expected 000101", remainder); end
        n_checks++;
        if ({overflow, div_zero} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b expected 00", {overflow, div_zero}); end
        @(negedge clk);
        n_checks++;
        if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL done_pulse: got done,busy=%b expected 00", {done, busy}); end
    endtask

    task automatic test_signs();
        int e;
        run_op(12'hFDD, 6'd6, e);          // -35 / 6
        n_checks++;
        if ({quotient, remainder} !== {6'b111011, 6'b111011}) begin
            n_fail++; $display("FAIL neg_dividend: got q=%b r=%b expected q=111011 r=111011", quotient, remainder);
        end
        run_op(12'd35, 6'b111010, e);      // 35 / -6
        n_checks++;
        if ({quotient, remainder} !== {6'b111011, 6'b000101}) begin
            n_fail++; $display("FAIL neg_divisor: got q=%b r=%b expected q=111011 r=000101", quotient, remainder);
        end
    endtask

    task automatic test_overflow();
        int e;
        run_op(12'hC00, 6'b100000, e);     // -1024 / -32 = 32
        n_checks++;
        if ({overflow, quotient, remainder} !== {1'b1, 6'b100000, 6'b000000}) begin
            n_fail++; $display("FAIL ovf_pos32: got ovf=%b q=%b r=%b expected ovf=1 q=100000 r=000000", overflow, quotient, remainder);
        end
        run_op(12'h400, 6'b100000, e);     // 1024 / -32 = -32
        n_checks++;
        if ({overflow, quotient, remainder} !== {1'b0, 6'b100000, 6'b000000}) begin
            n_fail++; $display("FAIL fit_neg32: got ovf=%b q=%b r=%b expected ovf=0 q=100000 r=000000", overflow, quotient, remainder);
        end
        run_op(12'h800, 6'd1, e);          // -2048 / 1
        n_checks++;
        if ({overflow, quotient, remainder} !== {1'b1, 6'b000000, 6'b000000}) begin
            n_fail++; $display("FAIL ovf_minval: got ovf=%b q=%b r=%b expected ovf=1 q=000000 r=000000", overflow, quotient, remainder);
        end
        run_op(12'd1000, 6'b100000, e);    // 1000 / -32 = -31 rem 8
        n_checks++;
        if ({overflow, quotient, remainder} !== {1'b0, 6'b100001, 6'b001000}) begin
            n_fail++; $display("FAIL div_m32: got ovf=%b q=%b r=%b expected ovf=0 q=100001 r=001000", overflow, quotient, remainder);
        end
    endtask

    task automatic test_div_zero();
        int e;
        run_op(12'd100, 6'd0, e);
        n_checks++;
        if (e !== 1) begin n_fail++; $display("FAIL dz_latency: got %0d expected 1", e); end
        n_checks++;
        if ({div_zero, overflow, quotient, remainder} !== {1'b1, 1'b0, 12'd0}) begin
            n_fail++; $display("FAIL dz_result: got dz=%b ovf=%b q=%b r=%b expected dz=1 ovf=0 q=0 r=0", div_zero, overflow, quotient, remainder);
        end
        run_op(12'd35, 6'd6, e);
        n_checks++;
        if ({div_zero, quotient} !== {1'b0, 6'd5}) begin
            n_fail++; $display("FAIL dz_clear: got dz=%b q=%b expected dz=0 q=000101", div_zero, quotient);
        end
    endtask

    task automatic test_busy_ignore();
        int e;
        @(negedge clk);
        start = 1'b1; dividend = 12'd35; divisor = 6'd6;
        @(posedge clk);
        @(negedge clk);
        dividend = 12'd20; divisor = 6'd3;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_high: got %b expected 1", busy); end
        e = 0;
        do begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (e == 4) start = 1'b0;
        end while (!done && e < 40);
        n_checks++;
        if ({e[7:0], quotient, remainder} !== {8'd13, 6'd5, 6'd5}) begin
            n_fail++; $display("FAIL busy_ignore: got edges=%0d q=%b r=%b expected edges=13 q=000101 r=000101", e, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        @(negedge clk);
        start = 1'b1; dividend = 12'd35; divisor = 6'd6;
        e = 0;
        do begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end while (!done && e < 40);
        n_checks++;
        if ({e[7:0], quotient} !== {8'd14, 6'd5}) begin
            n_fail++; $display("FAIL b2b_first: got edges=%0d q=%b expected edges=14 q=000101", e, quotient);
        end
        dividend = 12'hFDD;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        e = 0;
        do begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end while (!done && e < 40);
        n_checks++;
        if ({e[7:0], quotient, remainder} !== {8'd13, 6'b111011, 6'b111011}) begin
            n_fail++; $display("FAIL b2b_second: got edges=%0d q=%b r=%b expected edges=13 q=111011 r=111011", e, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid();
        int  e;
        logic saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 12'd35; divisor = 6'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, overflow, div_zero, quotient, remainder} !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid: got %h expected 0000", {busy, done, overflow, div_zero, quotient, remainder});
        end
        repeat (2) begin @(negedge clk); if (done) saw_done = 1'b1; end
        rst_n = 1'b1;
        repeat (20) begin @(negedge clk); if (done) saw_done = 1'b1; end
        n_checks++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL reset_no_done: got %b expected 0", saw_done); end
        run_op(12'd35, 6'd6, e);
        n_checks++;
        if ({e[7:0], quotient, remainder} !== {8'd13, 6'd5, 6'd5}) begin
            n_fail++; $display("FAIL reset_recover: got edges=%0d q=%b r=%b expected edges=13 q=000101 r=000101", e, quotient, remainder);
        end
    endtask

    task automatic test_roundtrip();
        int e;
        int rt_err;
        rt_err = 0;
        for (int a = -31; a <= 31; a++) begin
            if (a != 0) begin
                for (int b = -32; b <= 31; b++) begin
                    run_op(12'(a * b), 6'(a), e);
                    n_checks++;
                    if (e != 13 || quotient !== 6'(b) || remainder !== 6'd0 || overflow !== 1'b0) begin
                        n_fail++;
                        rt_err++;
                        $display("FAIL roundtrip a=%0d b=%0d: got edges=%0d q=%b r=%b ovf=%b expected edges=13 q=%b r=000000 ovf=0",
                                 a, b, e, quotient, remainder, overflow, 6'(b));
                    end
                end
            end
        end
        $display("roundtrip errors: %0d", rt_err);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_roundtrip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_div.md
Name: booth_div

Overview:
- Sequential signed divider; the inverse companion of the combinational booth multiplier.
- Takes a 2*width-bit signed product-domain dividend and a width-bit signed divisor, and returns a width-bit quotient and remainder.
- Uses an iterative restoring algorithm on magnitudes with a start/busy/done handshake.
- Sits beside booth in the arithmetic datapath; multiply-then-divide round trips must be exact.

Parameters:
- width, 6, operand width; dividend is 2*width bits, divisor/quotient/remainder are width bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  2*width  signed dividend, captured when start is accepted
- divisor  input  width  signed divisor, captured when start is accepted
- busy  output  1  high from the accept edge until done is asserted
- done  output  1  one-cycle pulse; result valid
- quotient  output  width  signed quotient, truncated toward zero
- remainder  output  width  signed remainder; sign follows dividend (Verilog / and % semantics)
- overflow  output  1  true quotient outside [-2^(width-1), 2^(width-1)-1]
- div_zero  output  1  divisor was zero

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy, done, quotient, remainder, overflow and div_zero all clear to 0.
  - Reset mid-operation aborts immediately; no done is produced.
- States: IDLE, CALC, FIX.
- IDLE:
  - On start=1 at edge E0: capture |dividend| (2*width-bit unsigned), |divisor| (width-bit unsigned), sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend).
  - Clear the partial remainder (width+1 bits) and the iteration counter; busy<=1.
  - Next state is CALC, or FIX if divisor==0.
- CALC: one restoring step per edge, MSB first.
  - Shift in the next dividend bit, trial-subtract |divisor|, keep the result if non-negative, set the quotient bit.
  - Runs exactly 2*width edges (E1..E2w), producing a full 2*width-bit quotient magnitude; then FIX.
- FIX, one edge: apply signs and publish; done<=1, busy<=0; next state IDLE.
  - quotient = low width bits of the signed quotient.
  - remainder = signed remainder.
  - overflow = (signed quotient does not fit in width bits).
- Latency:
  - Normal: done is high in the cycle after edge E(2*width+1) (13 edges for width=6).
  - Divide by zero: done after E1.
- done is high for exactly one cycle.
- Outputs hold their values until the next FIX. They are not cleared at start.
- start is ignored while busy=1. It is accepted in the cycle done=1 (state already IDLE), so back-to-back operations are allowed.
- Divide by zero: quotient=0, remainder=0, overflow=0, div_zero=1.
- div_zero and overflow are cleared at every FIX that does not set them.
- Negative-magnitude corner cases:
  - |-2^(2*width-1)| needs the full 2*width unsigned bits; |-2^(width-1)| needs width unsigned bits. Both must be handled without loss.
  - Remainder magnitude is < |divisor| ≤ 2^(width-1), so it always fits in signed width bits.
- Overflow case: quotient carries the truncated low bits and remainder is still exact.

Decomposition:
- Package booth_pkg holds:
  - the state enum (IDLE, CALC, FIX);
  - the default WIDTH constant;
  - a function returning the magnitude of a signed vector as an unsigned vector one bit wider-safe.
- One sub-module, div_step: combinational single restoring step.
  - Inputs: partial remainder, incoming dividend bit, divisor magnitude.
  - Outputs: next partial remainder and quotient bit.
  - Instantiated once; the FSM iterates it.

Test Plan:
- width=6, dividend=35, divisor=6, start pulse -> after 13 edges done=1, quotient=5, remainder=5, overflow=0, div_zero=0.
- dividend=-35, divisor=6 -> quotient=6'b111011 (-5), remainder=6'b111011 (-5). Then dividend=35, divisor=-6 -> quotient=-5, remainder=5.
- dividend=-1024, divisor=-32 -> overflow=1, quotient=6'b100000, remainder=0. Then dividend=-1024, divisor=32 -> overflow=0, quotient=-32.
- divisor=0, dividend=100 -> done after 1 edge, div_zero=1, quotient=0, remainder=0. Next op 35/6 clears div_zero.
- Round trip with the booth multiplier:
  - For all a in [-31,31] excluding 0 and all b in [-32,31]: dividend=a*b (2*width bits), divisor=a.
  - Required: quotient=b, remainder=0, overflow=0 for every pair; the error count is reported at the end.
- Control corner cases:
  - start re-asserted while busy -> ignored, result unchanged.
  - start held high across done -> back-to-back result.
  - rst_n=0 at edge E5 -> all outputs 0 immediately, no done pulse; a new start after release completes normally.
